// File: rtl/pdm2pcm_channel_scheduler.sv
// PDM2PCM front-end channel scheduler.
// Generates the PDM microphone clock and synchronises the shared PDM data pad.
// Left is captured at the end of each high phase and right (stereo only) at the
// end of each low phase; captures are serialised onto a single pdm/valid/channel
// stream. The warm-up interval is discarded with the pipeline held in reset.
module pdm2pcm_channel_scheduler #(
  parameter int DIV_WIDTH    = 8,
  parameter int WARMUP_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    stereo_i,
  input  logic [DIV_WIDTH-1:0]    clock_divisor_i,
  input  logic [WARMUP_WIDTH-1:0] warmup_periods_i,
  input  logic                    pdm_data_i,
  output logic                    pdm_clk_o,
  output logic                    pdm_o,
  output logic                    valid_o,
  output logic                    channel_o,
  output logic                    pipe_enable_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WARMUP = 2'b01,
    ST_RUN    = 2'b10,
    ST_STOP   = 2'b11
  } state_e;

  localparam logic [DIV_WIDTH-1:0]    DIV_ZERO  = DIV_WIDTH'(0);
  localparam logic [DIV_WIDTH-1:0]    DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]    DIV_MIN   = DIV_WIDTH'(2);
  localparam logic [WARMUP_WIDTH-1:0] WARM_ZERO = WARMUP_WIDTH'(0);
  localparam logic [WARMUP_WIDTH-1:0] WARM_ONE  = WARMUP_WIDTH'(1);

  state_e                  state_r;
  state_e                  state_next_s;

  logic                    sync1_r;
  logic                    sync2_r;

  logic [DIV_WIDTH-1:0]    cnt_r;
  logic                    pdm_clk_r;
  logic [DIV_WIDTH-1:0]    div_q_r;
  logic                    stereo_q_r;
  logic [WARMUP_WIDTH-1:0] warm_q_r;

  logic                    cap_valid_r;
  logic                    cap_bit_r;
  logic                    cap_chan_r;

  logic                    pdm_r;
  logic                    valid_r;
  logic                    channel_r;
  logic                    pipe_en_r;
  logic                    busy_r;

  logic                    toggle_s;
  logic                    rise_s;
  logic                    fall_s;
  logic                    capture_s;
  logic                    capture_chan_s;
  logic                    warm_dec_s;
  logic [DIV_WIDTH-1:0]    div_clamp_s;

  // Toggle decode: end of the current half-period and its direction.
  always_comb begin
    toggle_s = (cnt_r == (div_q_r - DIV_ONE));
    rise_s   = toggle_s & ~pdm_clk_r;
    fall_s   = toggle_s & pdm_clk_r;
    if (clock_divisor_i < DIV_MIN) begin
      div_clamp_s = DIV_MIN;
    end else begin
      div_clamp_s = clock_divisor_i;
    end
  end

  // Two-flop synchroniser for the asynchronous PDM data pad.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pdm_data_i;
      sync2_r <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_next_s   = state_r;
    capture_s      = 1'b0;
    capture_chan_s = 1'b0;
    warm_dec_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) begin
          if (warmup_periods_i == WARM_ZERO) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_WARMUP;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (!enable_i) begin
          state_next_s = ST_STOP;
        end else if (rise_s) begin
          // A rising toggle closes one full discarded period.
          warm_dec_s = 1'b1;
          if (warm_q_r == WARM_ONE) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_WARMUP;
          end
        end else begin
          state_next_s = ST_WARMUP;
        end
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_next_s = ST_STOP;
        end else if (fall_s) begin
          capture_s      = 1'b1;
          capture_chan_s = 1'b0;
        end else if (rise_s && stereo_q_r) begin
          capture_s      = 1'b1;
          capture_chan_s = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_STOP: begin
        // Leave only once the microphone clock is back low.
        if (!pdm_clk_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Half-period counter and PDM clock generation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r     <= DIV_ZERO;
      pdm_clk_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r     <= DIV_ZERO;
          pdm_clk_r <= enable_i;
        end
        ST_STOP: begin
          if (!pdm_clk_r) begin
            // Already low: hold it there so no stray rising edge escapes.
            cnt_r     <= DIV_ZERO;
            pdm_clk_r <= 1'b0;
          end else if (toggle_s) begin
            cnt_r     <= DIV_ZERO;
            pdm_clk_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + DIV_ONE;
          end
        end
        default: begin
          if (toggle_s) begin
            cnt_r     <= DIV_ZERO;
            pdm_clk_r <= ~pdm_clk_r;
          end else begin
            cnt_r <= cnt_r + DIV_ONE;
          end
        end
      endcase
    end
  end

  // Configuration latched at start and the warm-up period countdown.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q_r    <= DIV_MIN;
      stereo_q_r <= 1'b0;
      warm_q_r   <= WARM_ZERO;
    end else if ((state_r == ST_IDLE) && enable_i) begin
      div_q_r    <= div_clamp_s;
      stereo_q_r <= stereo_i;
      warm_q_r   <= warmup_periods_i;
    end else if (warm_dec_s) begin
      warm_q_r <= warm_q_r - WARM_ONE;
    end
  end

  // Capture stage: holds the bit and channel taken at a toggle edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_valid_r <= 1'b0;
      cap_bit_r   <= 1'b0;
      cap_chan_r  <= 1'b0;
    end else begin
      cap_valid_r <= capture_s;
      if (capture_s) begin
        cap_bit_r  <= sync2_r;
        cap_chan_r <= capture_chan_s;
      end
    end
  end

  // Output stage: issues the capture one cycle after its toggle edge, dropped if
  // the run is being stopped on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pdm_r     <= 1'b0;
      valid_r   <= 1'b0;
      channel_r <= 1'b0;
    end else begin
      valid_r <= cap_valid_r && (state_next_s == ST_RUN);
      if (cap_valid_r && (state_next_s == ST_RUN)) begin
        pdm_r     <= cap_bit_r;
        channel_r <= cap_chan_r;
      end
    end
  end

  // Status outputs registered from the next state so they move with transitions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_en_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      pipe_en_r <= (state_next_s == ST_RUN);
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  assign pdm_clk_o     = pdm_clk_r;
  assign pdm_o         = pdm_r;
  assign valid_o       = valid_r;
  assign channel_o     = channel_r;
  assign pipe_enable_o = pipe_en_r;
  assign busy_o        = busy_r;

endmodule
